uart_rx_core: RTL and testbench

Receive half of the UART. Recovers 8N1 (configurable data width) frames from the asynchronous `rx` line using a one-cycle 16x-oversample enable from the baud generator. Delivers each byte over a valid/ready handshake toward the APB-side register block. Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_sampler.sv | 45 ++++
 rtl/uart_rx_core.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_core.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and oversampling constants (used by rx and tx)
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;

  // Mid-bit sample points within one bit period at 16x oversampling
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - rx synchroniser and three-sample majority bit decision
module uart_rx_sampler (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  input  logic sample_lo,
  input  logic sample_mid,
  output logic rx_s,
  output logic bit_val
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic s_lo_q, s_lo_d;
  logic s_mid_q, s_mid_d;

  // Next-state: shift the synchroniser, capture the two early samples on their strobes
  always_comb begin
    sync1_d = rx;
    sync2_d = sync1_q;
    s_lo_d  = sample_lo  ? sync2_q : s_lo_q;
    s_mid_d = sample_mid ? sync2_q : s_mid_q;
  end

  // State registers; line idles high so everything resets to 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      s_lo_q  <= 1'b1;
      s_mid_q <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
    end
  end

  assign rx_s = sync2_q;

  // Third sample is the live rx_s on the decision tick
  assign bit_val = (s_lo_q & s_mid_q) | (s_lo_q & rx_s) | (s_mid_q & rx_s);

endmodule

// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: frame FSM, shift register and valid/ready output
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] CNT_LO  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_MID = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] CNT_HI  = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;

  logic [CNT_W-1:0] cnt_nxt;
  logic in_frame, sample_lo, sample_mid, decide, wrap, complete;
  logic rx_s, bit_val;

  uart_rx_sampler u_sampler (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .sample_lo  (sample_lo),
    .sample_mid (sample_mid),
    .rx_s       (rx_s),
    .bit_val    (bit_val)
  );

  // Tick bookkeeping: counter value after this tick and the strobes that depend on it
  always_comb begin
    cnt_nxt    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    in_frame   = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    sample_lo  = rx_tick && in_frame && (cnt_nxt == CNT_LO);
    sample_mid = rx_tick && in_frame && (cnt_nxt == CNT_MID);
    decide     = rx_tick && in_frame && (cnt_nxt == CNT_HI);
    wrap       = rx_tick && in_frame && (cnt_nxt == '0);
  end

  // Frame FSM plus output handshake (completion may coincide with an accept)
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_err_d  = 1'b0;
    overrun_d    = 1'b0;
    complete     = 1'b0;
    if (in_frame && rx_tick) cnt_d = cnt_nxt;
    case (state_q)
      IDLE: begin
        if (rx_tick && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (decide && bit_val) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (wrap) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (decide) shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (idx_q == IDX_LAST) state_d = STOP;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      STOP: begin
        if (decide) begin
          cnt_d = '0;
          if (bit_val) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (complete) begin
      if (!data_valid_q || data_ready) begin
        data_out_d   = shreg_q;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb/tb_uart_rx_core.sv - directed self-checking bench for uart_rx_core
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rx = 1'b1;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, frame_err, overrun, busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int div = 0;
  int ovr_seen = 0;
  int fe_seen = 0;
  int dv_rise = 0;
  logic dv_prev = 1'b0;

  uart_rx_core #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_tick    (rx_tick),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks, updated on the falling edge
  initial forever begin
    @(negedge clk);
    div = (div == 3) ? 0 : div + 1;
    rx_tick = (div == 0);
  end

  // Pulse and rising-edge counters
  always @(negedge clk) begin
    if (overrun) ovr_seen <= ovr_seen + 1;
    if (frame_err) fe_seen <= fe_seen + 1;
    if (data_valid && !dv_prev) dv_rise <= dv_rise + 1;
    dv_prev <= data_valid;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_tick();
    @(posedge clk);
    while (!rx_tick) @(posedge clk);
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) wait_tick();
  endtask

  // Returns right after the stop bit is driven (144 ticks after the start edge)
  task automatic drive_frame(input logic [7:0] d, input logic stop);
    wait_tick();
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    rx = stop;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++; if (data_out !== 8'h00) begin err_cnt++; $display("FAIL reset_data_out got=%h exp=00", data_out); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_data_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_single_frame();
    data_ready = 1'b1;
    drive_frame(8'h55, 1'b1);
    wait_ticks(9);
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL single_early_valid got=%b exp=0", data_valid); end
    wait_tick();
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL single_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (data_out !== 8'h55) begin err_cnt++; $display("FAIL single_data got=%h exp=55", data_out); end
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL single_frame_err got=%b exp=0", frame_err); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL single_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL single_accept got=%b exp=0", data_valid); end
    wait_ticks(6);
  endtask

  task automatic test_overrun();
    int o0;
    data_ready = 1'b0;
    o0 = ovr_seen;
    drive_frame(8'hA5, 1'b1);
    wait_ticks(16);
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_first_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (data_out !== 8'hA5) begin err_cnt++; $display("FAIL ovr_first_data got=%h exp=a5", data_out); end
    drive_frame(8'h3C, 1'b1);
    wait_ticks(9);
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_early got=%b exp=0", overrun); end
    wait_tick();
    vec_cnt++; if (overrun !== 1'b1) begin err_cnt++; $display("FAIL ovr_pulse got=%b exp=1", overrun); end
    vec_cnt++; if (data_out !== 8'hA5) begin err_cnt++; $display("FAIL ovr_keep_data got=%h exp=a5", data_out); end
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL ovr_keep_valid got=%b exp=1", data_valid); end
    @(posedge clk); #1;
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL ovr_pulse_width got=%b exp=0", overrun); end
    wait_ticks(6);
    vec_cnt++; if (ovr_seen - o0 !== 1) begin err_cnt++; $display("FAIL ovr_count got=%0d exp=1", ovr_seen - o0); end
    data_ready = 1'b1;
    @(posedge clk); #1;
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL ovr_drain_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (data_out !== 8'hA5) begin err_cnt++; $display("FAIL ovr_drain_data got=%h exp=a5", data_out); end
    wait_ticks(2);
  endtask

  task automatic test_glitch();
    int d0;
    data_ready = 1'b1;
    d0 = dv_rise;
    wait_tick();
    rx = 1'b0;
    wait_ticks(2);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL glitch_busy got=%b exp=1", busy); end
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(8);
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    vec_cnt++; if (dv_rise - d0 !== 0) begin err_cnt++; $display("FAIL glitch_no_byte got=%0d exp=0", dv_rise - d0); end
    drive_frame(8'h0F, 1'b1);
    wait_ticks(10);
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL glitch_next_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (data_out !== 8'h0F) begin err_cnt++; $display("FAIL glitch_next_data got=%h exp=0f", data_out); end
    wait_ticks(6);
  endtask

  task automatic test_framing();
    int f0, d0;
    data_ready = 1'b1;
    f0 = fe_seen;
    d0 = dv_rise;
    drive_frame(8'h81, 1'b0);
    wait_ticks(9);
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL fe_early got=%b exp=0", frame_err); end
    wait_tick();
    vec_cnt++; if (frame_err !== 1'b1) begin err_cnt++; $display("FAIL fe_pulse got=%b exp=1", frame_err); end
    @(posedge clk); #1;
    vec_cnt++; if (frame_err !== 1'b0) begin err_cnt++; $display("FAIL fe_pulse_width got=%b exp=0", frame_err); end
    wait_ticks(40);
    vec_cnt++; if (busy !== 1'b1) begin err_cnt++; $display("FAIL fe_break_busy got=%b exp=1", busy); end
    vec_cnt++; if (fe_seen - f0 !== 1) begin err_cnt++; $display("FAIL fe_count got=%0d exp=1", fe_seen - f0); end
    vec_cnt++; if (dv_rise - d0 !== 0) begin err_cnt++; $display("FAIL fe_no_byte got=%0d exp=0", dv_rise - d0); end
    rx = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL fe_break_exit got=%b exp=0", busy); end
    wait_ticks(4);
    drive_frame(8'h42, 1'b1);
    wait_ticks(10);
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL fe_next_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (data_out !== 8'h42) begin err_cnt++; $display("FAIL fe_next_data got=%h exp=42", data_out); end
    wait_ticks(6);
  endtask

  task automatic test_back_to_back();
    int o0;
    data_ready = 1'b0;
    o0 = ovr_seen;
    drive_frame(8'hDE, 1'b1);
    wait_ticks(16);
    vec_cnt++; if (data_out !== 8'hDE) begin err_cnt++; $display("FAIL b2b_first_data got=%h exp=de", data_out); end
    drive_frame(8'hAD, 1'b1);
    wait_ticks(9);
    @(negedge clk); #1;
    while (!rx_tick) begin @(negedge clk); #1; end
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    vec_cnt++; if (data_out !== 8'hAD) begin err_cnt++; $display("FAIL b2b_data got=%h exp=ad", data_out); end
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (overrun !== 1'b0) begin err_cnt++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    @(posedge clk); #1;
    vec_cnt++; if (ovr_seen - o0 !== 0) begin err_cnt++; $display("FAIL b2b_ovr_count got=%0d exp=0", ovr_seen - o0); end
    data_ready = 1'b1;
    @(posedge clk); #1;
    data_ready = 1'b0;
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_accept got=%b exp=0", data_valid); end
    wait_ticks(6);
  endtask

  task automatic test_reset_mid_frame();
    int d0, f0;
    data_ready = 1'b0;
    wait_tick();
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx = 1'b0;
      wait_ticks(16);
    end
    rx = 1'b1;
    wait_ticks(8);
    d0 = dv_rise;
    f0 = fe_seen;
    rst = 1'b1;
    #1;
    vec_cnt++; if (data_out !== 8'h00) begin err_cnt++; $display("FAIL rmid_data_out got=%h exp=00", data_out); end
    vec_cnt++; if (data_valid !== 1'b0) begin err_cnt++; $display("FAIL rmid_valid got=%b exp=0", data_valid); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    vec_cnt++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin err_cnt++; $display("FAIL rmid_pulses got=%b%b exp=00", frame_err, overrun); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_ticks(72);
    vec_cnt++; if (dv_rise - d0 !== 0) begin err_cnt++; $display("FAIL rmid_no_byte got=%0d exp=0", dv_rise - d0); end
    vec_cnt++; if (fe_seen - f0 !== 0) begin err_cnt++; $display("FAIL rmid_no_fe got=%0d exp=0", fe_seen - f0); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL rmid_idle got=%b exp=0", busy); end
    data_ready = 1'b1;
    drive_frame(8'h99, 1'b1);
    wait_ticks(10);
    vec_cnt++; if (data_valid !== 1'b1) begin err_cnt++; $display("FAIL rmid_next_valid got=%b exp=1", data_valid); end
    vec_cnt++; if (data_out !== 8'h99) begin err_cnt++; $display("FAIL rmid_next_data got=%h exp=99", data_out); end
    wait_ticks(6);
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_overrun();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
